// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher with a word-serial inverse S-box.
// Optional AES_DEC_OUTPUT_MASK_EN: new_block reads as zero while a block is in flight.

module aes_inv_sbox (
    input  logic [31:0] sword,
    output logic [31:0] new_sword
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i])
                p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Undo the affine transform, then invert in GF(2^8) as y^254 (0 maps to 0).
    function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] sq;
        logic [7:0] acc;
        y   = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        sq  = y;
        acc = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    always_comb begin
        new_sword = {inv_sub_byte(sword[31:24]), inv_sub_byte(sword[23:16]),
                     inv_sub_byte(sword[15:8]),  inv_sub_byte(sword[7:0])};
    end

endmodule

module aes_decipher_block #(
    parameter logic [3:0] AES128_ROUNDS = 4'ha,
    parameter logic [3:0] AES256_ROUNDS = 4'he
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [2:0] {IDLE, INIT, SBOX, MAIN, FINAL} state_t;

    state_t      fsm_state;
    logic [31:0] w0, w1, w2, w3;
    logic [3:0]  round_ctr;
    logic [1:0]  sword_ctr;
    logic        keylen_reg;
    logic        ready_reg;
    logic [3:0]  num_rounds;
    logic [31:0] sbox_in;
    logic [31:0] sbox_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i])
                p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Byte (col c, row r) lives at bits 127-8*(4c+r); row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
        return t;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            t[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            t[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            t[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            t[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return t;
    endfunction

    assign num_rounds = keylen_reg ? AES256_ROUNDS : AES128_ROUNDS;

    always_comb begin
        sbox_in = w0;
        case (sword_ctr)
            2'd1:    sbox_in = w1;
            2'd2:    sbox_in = w2;
            2'd3:    sbox_in = w3;
            default: sbox_in = w0;
        endcase
    end

    aes_inv_sbox inv_sbox_inst (
        .sword     (sbox_in),
        .new_sword (sbox_out)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_state  <= IDLE;
            round_ctr  <= '0;
            sword_ctr  <= '0;
            w0         <= '0;
            w1         <= '0;
            w2         <= '0;
            w3         <= '0;
            ready_reg  <= 1'b1;
            keylen_reg <= 1'b0;
        end else begin
            case (fsm_state)
                IDLE: begin
                    if (next) begin
                        keylen_reg <= keylen;
                        round_ctr  <= keylen ? AES256_ROUNDS : AES128_ROUNDS;
                        ready_reg  <= 1'b0;
                        fsm_state  <= INIT;
                    end
                end
                INIT: begin
                    {w0, w1, w2, w3} <= inv_shift_rows(block ^ round_key);
                    // round_ctr equals num_rounds here, so this is round_ctr-1.
                    round_ctr <= num_rounds - 4'h1;
                    sword_ctr <= '0;
                    fsm_state <= SBOX;
                end
                SBOX: begin
                    case (sword_ctr)
                        2'd0:    w0 <= sbox_out;
                        2'd1:    w1 <= sbox_out;
                        2'd2:    w2 <= sbox_out;
                        default: w3 <= sbox_out;
                    endcase
                    sword_ctr <= sword_ctr + 2'd1;
                    if (sword_ctr == 2'd3)
                        fsm_state <= (round_ctr == 4'h0) ? FINAL : MAIN;
                end
                MAIN: begin
                    {w0, w1, w2, w3} <= inv_shift_rows(inv_mix_columns({w0, w1, w2, w3} ^ round_key));
                    round_ctr <= round_ctr - 4'h1;
                    sword_ctr <= '0;
                    fsm_state <= SBOX;
                end
                FINAL: begin
                    {w0, w1, w2, w3} <= {w0, w1, w2, w3} ^ round_key;
                    ready_reg <= 1'b1;
                    fsm_state <= IDLE;
                end
                default: fsm_state <= IDLE;
            endcase
        end
    end

    assign round = round_ctr;
    assign ready = ready_reg;

`ifdef AES_DEC_OUTPUT_MASK_EN
    assign new_block = ready_reg ? {w0, w1, w2, w3} : '0;
`else
    assign new_block = {w0, w1, w2, w3};
`endif

endmodule
